instr_fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue MIPS datapath. It owns the program counter and drives the instruction memory read port. It buffers fetched words in a 2-entry queue and hands {instruction, PC, PC+4} to the field-decode stage over a valid/ready handshake. J-type jumps (opcode 2) are resolved in fetch with no delay slot; all other control-flow changes arrive from downstream as a redirect.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch-stage buses: the instruction memory read port, the downstream
// redirect request and the valid/ready handshake towards field decode.
//   master : used by instr_fetch_unit (drives imem address/read and the decode outputs)
//   slave  : used by the environment (memory, decode, branch resolution)
interface instr_fetch_unit_if;
    logic [31:0] imemAddr;
    logic        imemRead;
    logic [31:0] imemData;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic [31:0] outPcPlus4;

    modport master (
        output imemAddr, imemRead, outValid, outInstr, outPc, outPcPlus4,
        input  imemData, redirect, redirectPc, outReady
    );

    modport slave (
        input  imemAddr, imemRead, outValid, outInstr, outPc, outPcPlus4,
        output imemData, redirect, redirectPc, outReady
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory, buffers fetched words
// in a 2-entry queue and presents {instr, pc, pc+4} to decode over valid/ready.
// J-type jumps (opcode 2) are resolved here with no delay slot; other control-flow changes
// arrive as a downstream redirect, which flushes the queue.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_fetch_unit_if.master (imem port, redirect, decode handshake)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd128
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_unit_if.master  bus
);

    localparam logic [5:0] OpJ = 6'd2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q [2];
    logic [31:0] epc_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;

    logic        pop, push, space;
    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4     = pc_q + 32'd4;
        bus.imemAddr = pc_q;

        bus.outValid = (count_q != 2'd0) && !bus.redirect;
        pop          = bus.outValid && bus.outReady;
        space        = (count_q < 2'd2) || pop;
        // No fetch while reset is held, so the memory sees no read before the PC is valid.
        push         = !bus.redirect && space && !reset;
        bus.imemRead = push;

        if (count_q != 2'd0) begin
            bus.outInstr = instr_q[rd_ptr_q];
            bus.outPc    = epc_q[rd_ptr_q];
        end else begin
            bus.outInstr = 32'd0;
            bus.outPc    = 32'd0;
        end
        bus.outPcPlus4 = bus.outPc + 32'd4;

        pc_d = pc_q;
        if (push) begin
            if (bus.imemData[31:26] == OpJ) begin
                // Jump target stays in the 256 MB region of the delay-slot address.
                pc_d = {pc_plus4[31:28], bus.imemData[25:0], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= 32'd0;
                epc_q[i]   <= 32'd0;
            end
        end else if (bus.redirect) begin
            pc_q     <= {bus.redirectPc[31:2], 2'b00};
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            if (push) begin
                instr_q[wr_ptr_q] <= bus.imemData;
                epc_q[wr_ptr_q]   <= pc_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a cycle-by-cycle vector table covering reset,
// backpressure, redirect, reset-over-redirect and PC wrap, then scoreboarded streams for
// straight-line fetch and a J-type jump under random backpressure.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    bit   jmode;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'd128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory image: a non-jump word derived from the address, plus a J at 132 in jump mode.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit jm);
        if (jm && a == 32'd132) return 32'h0800_0030;
        return 32'h2000_0000 ^ a;
    endfunction

    assign bus.imemData = mem_word(bus.imemAddr, jmode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_val;
        logic        e_head;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rpc,
                                input logic rdy, input logic e_rd, input logic [31:0] e_addr,
                                input logic e_val, input logic e_head, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.e_rd = e_rd;
        v.e_addr = e_addr; v.e_val = e_val; v.e_head = e_head; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t        vecs [17];
    logic [31:0] expq [$];

    // Pop the scoreboard on every completed handshake and compare the presented entry.
    task automatic sb_sample();
        logic [31:0] e;
        if (bus.outValid && bus.outReady) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h expected no output", bus.outPc);
            end else begin
                e = expq.pop_front();
                chk("sb_pc", bus.outPc, e);
                chk("sb_instr", bus.outInstr, mem_word(e, jmode));
                chk("sb_pc4", bus.outPcPlus4, e + 32'd4);
            end
        end
    endtask

    initial begin
        int          first_rd, first_val;
        logic [31:0] exp_fetch, prev_fetch, held_pc;
        bit          saw136, was_stalled;

        vecs[0]  = mk(1, 0, 0, 0,            0, 32'd128,      0, 0, 32'd0);
        vecs[1]  = mk(0, 0, 0, 0,            1, 32'd128,      0, 0, 32'd0);
        vecs[2]  = mk(0, 0, 0, 0,            1, 32'd132,      1, 1, 32'd128);
        vecs[3]  = mk(0, 0, 0, 0,            0, 32'd136,      1, 1, 32'd128);
        vecs[4]  = mk(0, 0, 0, 0,            0, 32'd136,      1, 1, 32'd128);
        vecs[5]  = mk(0, 0, 0, 1,            1, 32'd136,      1, 1, 32'd128);
        vecs[6]  = mk(0, 0, 0, 1,            1, 32'd140,      1, 1, 32'd132);
        vecs[7]  = mk(0, 1, 32'h203, 1,      0, 32'd144,      0, 1, 32'd136);
        vecs[8]  = mk(0, 0, 0, 1,            1, 32'h200,      0, 0, 32'd0);
        vecs[9]  = mk(0, 0, 0, 1,            1, 32'h204,      1, 1, 32'h200);
        vecs[10] = mk(0, 0, 0, 0,            1, 32'h208,      1, 1, 32'h204);
        vecs[11] = mk(1, 1, 32'h400, 0,      0, 32'h20C,      0, 1, 32'h204);
        vecs[12] = mk(0, 0, 0, 1,            1, 32'd128,      0, 0, 32'd0);
        vecs[13] = mk(0, 0, 0, 1,            1, 32'd132,      1, 1, 32'd128);
        vecs[14] = mk(0, 1, 32'hFFFF_FFFE, 1, 0, 32'd136,     0, 1, 32'd132);
        vecs[15] = mk(0, 0, 0, 1,            1, 32'hFFFF_FFFC, 0, 0, 32'd0);
        vecs[16] = mk(0, 0, 0, 1,            1, 32'h0,        1, 1, 32'hFFFF_FFFC);

        // Vector table
        jmode          = 1'b0;
        reset          = 1'b1;
        bus.redirect   = 1'b0;
        bus.redirectPc = 32'd0;
        bus.outReady   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            reset          = vecs[i].rst;
            bus.redirect   = vecs[i].rdr;
            bus.redirectPc = vecs[i].rpc;
            bus.outReady   = vecs[i].rdy;
            #4;
            chk($sformatf("v%0d_imemRead", i), {31'd0, bus.imemRead}, {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_imemAddr", i), bus.imemAddr, vecs[i].e_addr);
            chk($sformatf("v%0d_outValid", i), {31'd0, bus.outValid}, {31'd0, vecs[i].e_val});
            chk($sformatf("v%0d_outPc", i), bus.outPc, vecs[i].e_pc);
            chk($sformatf("v%0d_outPcPlus4", i), bus.outPcPlus4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d_outInstr", i), bus.outInstr,
                vecs[i].e_head ? mem_word(vecs[i].e_pc, jmode) : 32'd0);
            @(posedge clk);
            #1;
        end

        // Straight-line fetch, outReady held high
        reset        = 1'b1;
        bus.redirect = 1'b0;
        bus.outReady = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        for (int k = 0; k < 11; k++) expq.push_back(32'd128 + 32'(4 * k));
        first_rd  = -1;
        first_val = -1;
        exp_fetch = 32'd128;
        for (int cyc = 0; cyc < 40 && expq.size() != 0; cyc++) begin
            #4;
            if (bus.imemRead && first_rd < 0) first_rd = cyc;
            if (bus.outValid && first_val < 0) first_val = cyc;
            if (bus.imemRead && exp_fetch <= 32'd168) begin
                chk("line_fetch_addr", bus.imemAddr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            sb_sample();
            @(posedge clk);
            #1;
        end
        chk("line_first_fetch", first_rd, 0);
        chk("line_latency", first_val - first_rd, 1);
        chk("line_drained", expq.size(), 0);

        // J-type at 132 under random backpressure
        jmode        = 1'b1;
        reset        = 1'b1;
        bus.outReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        expq.push_back(32'd128);
        expq.push_back(32'd132);
        for (int k = 0; k < 6; k++) expq.push_back(32'd192 + 32'(4 * k));
        saw136      = 1'b0;
        prev_fetch  = 32'd0;
        was_stalled = 1'b0;
        held_pc     = 32'd0;
        for (int cyc = 0; cyc < 80 && expq.size() != 0; cyc++) begin
            bus.outReady = 1'($urandom_range(0, 1));
            #4;
            if (was_stalled) chk("stall_stable_pc", bus.outPc, held_pc);
            if (bus.imemRead) begin
                if (bus.imemAddr == 32'd136) saw136 = 1'b1;
                if (bus.imemAddr == 32'd192) chk("jump_prev_fetch", prev_fetch, 32'd132);
                prev_fetch = bus.imemAddr;
            end
            was_stalled = bus.outValid && !bus.outReady;
            held_pc     = bus.outPc;
            sb_sample();
            @(posedge clk);
            #1;
        end
        chk("jump_no_136", {31'd0, saw136}, 32'd0);
        chk("jump_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
